softmax_vec_loader: RTL

Front-end stage for the `softmax` block. It accepts fp16 elements one per beat on a valid/ready stream and packs `NUM` consecutive beats into a vector. It then drives `inp`, `sub0_inp` and `sub1_inp` with identical copies of that vector and issues a one-cycle `start`. It enforces a minimum spacing of `SM_LATENCY` cycles between starts, and double-buffers so the next vector can fill while `softmax` is still busy.

---
 rtl/softmax_pkg.sv | 21 ++
 rtl/softmax_issue_timer.sv | 41 ++++
 rtl/softmax_vec_loader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/softmax_pkg.sv
// softmax_pkg: shared element width, lane count, fp16 type and the fp16
// ordering helper used by the softmax front-end.
package softmax_pkg;

  localparam int DATAWIDTH = 16;
  localparam int NUM       = 4;

  typedef logic [DATAWIDTH-1:0] fp16_t;

  // Sign-magnitude greater-than. Each operand is mapped to a signed key of
  // +/- magnitude, so -0 and +0 both map to 0 and compare equal. NaN is not
  // special-cased; it orders by its raw magnitude bits.
  function automatic logic fp16_gt(input fp16_t a, input fp16_t b);
    logic signed [16:0] ka;
    logic signed [16:0] kb;
    ka = a[15] ? -$signed({2'b00, a[14:0]}) : $signed({2'b00, a[14:0]});
    kb = b[15] ? -$signed({2'b00, b[14:0]}) : $signed({2'b00, b[14:0]});
    return ka > kb;
  endfunction

endpackage

// File: rtl/softmax_issue_timer.sv
// softmax_issue_timer: spacing window between softmax starts.
// Loading the counter opens a window of SM_LATENCY cycles during which busy
// is high. open_o tells the issuer the window is closed by the coming edge.
module softmax_issue_timer #(
  parameter int SM_LATENCY = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic busy_o,
  output logic open_o
);

  localparam int CW = (SM_LATENCY > 1) ? $clog2(SM_LATENCY + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Reload on issue, otherwise count down to zero and stay there.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CW'(SM_LATENCY);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  // Counter register; reset cancels any open window.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);
  // A count of 1 reaches zero on this edge, so an issue on this edge lands
  // exactly SM_LATENCY cycles after the previous one while busy stays high
  // for exactly SM_LATENCY cycles per issue.
  assign open_o = (cnt_q <= CW'(1));

endmodule

// File: rtl/softmax_vec_loader.sv
// softmax_vec_loader: packs NUM fp16 beats from a valid/ready stream into a
// vector, then issues it to softmax (inp, sub0_inp, sub1_inp plus a one-cycle
// start) no more often than once per SM_LATENCY cycles. The fill buffer is
// separate from the issued vector so the next vector fills while busy.
// Optional feature: define SOFTMAX_LOADER_MAX_EN to track the maximum element
// of each vector and present it on vec_max; otherwise vec_max is tied to 0.
module softmax_vec_loader #(
  parameter int DATAWIDTH  = 16,
  parameter int NUM        = 4,
  parameter int SM_LATENCY = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATAWIDTH-1:0]     in_data,
  output logic [DATAWIDTH*NUM-1:0] inp,
  output logic [DATAWIDTH*NUM-1:0] sub0_inp,
  output logic [DATAWIDTH*NUM-1:0] sub1_inp,
  output logic                     start,
  output logic                     busy,
  output logic [DATAWIDTH-1:0]     vec_max,
  output logic [15:0]              issue_count
);

  import softmax_pkg::*;

  localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;

  // fill side
  logic [NUM-1:0][DATAWIDTH-1:0] lanes_q, lanes_d;
  logic [IW-1:0]                 fill_idx_q, fill_idx_d;
  logic                          full_q, full_d;

  // issue side
  logic [DATAWIDTH*NUM-1:0]      vec_q, vec_d;
  logic                          start_q, start_d;
  logic [15:0]                   cnt_q, cnt_d;

  logic accept;
  logic issue;
  logic win_open;

  // Ready drops only while a complete vector waits, or during reset.
  assign in_ready = !full_q && reset;
  assign accept   = in_valid && in_ready;
  // accept needs !full and issue needs full, so they never share an edge
  // for the same vector; lane 0 of the next one is taken the edge after.
  assign issue    = full_q && win_open;

  softmax_issue_timer #(
    .SM_LATENCY(SM_LATENCY)
  ) u_timer (
    .clk_i (clk),
    .rst_ni(reset),
    .load_i(issue),
    .busy_o(busy),
    .open_o(win_open)
  );

  // Fill buffer: write the accepted beat to the current lane, wrap the index
  // after the last lane and mark the buffer full until it is issued.
  always_comb begin
    lanes_d    = lanes_q;
    fill_idx_d = fill_idx_q;
    full_d     = full_q;
    if (issue)
      full_d = 1'b0;
    if (accept) begin
      lanes_d[fill_idx_q] = in_data;
      if (fill_idx_q == IW'(NUM - 1)) begin
        fill_idx_d = '0;
        full_d     = 1'b1;
      end else begin
        fill_idx_d = fill_idx_q + IW'(1);
      end
    end
  end

  // Issue side: snapshot the buffer, pulse start, count issued vectors.
  always_comb begin
    vec_d   = vec_q;
    start_d = 1'b0;
    cnt_d   = cnt_q;
    if (issue) begin
      vec_d   = lanes_q;
      start_d = 1'b1;
      cnt_d   = cnt_q + 16'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lanes_q    <= '0;
      fill_idx_q <= '0;
      full_q     <= 1'b0;
      vec_q      <= '0;
      start_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      lanes_q    <= lanes_d;
      fill_idx_q <= fill_idx_d;
      full_q     <= full_d;
      vec_q      <= vec_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
    end
  end

  assign inp         = vec_q;
  assign sub0_inp    = vec_q;
  assign sub1_inp    = vec_q;
  assign start       = start_q;
  assign issue_count = cnt_q;

`ifdef SOFTMAX_LOADER_MAX_EN
  logic [DATAWIDTH-1:0] run_max_q, run_max_d;
  logic [DATAWIDTH-1:0] vec_max_q, vec_max_d;

  // Running max over the vector being filled; lane 0 seeds it so no stale
  // value from the previous vector leaks in. Published on the issue edge.
  always_comb begin
    run_max_d = run_max_q;
    vec_max_d = vec_max_q;
    if (accept && ((fill_idx_q == '0) ||
                   fp16_gt(fp16_t'(in_data), fp16_t'(run_max_q))))
      run_max_d = in_data;
    if (issue)
      vec_max_d = run_max_q;
  end

  // Max registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_max_q <= '0;
      vec_max_q <= '0;
    end else begin
      run_max_q <= run_max_d;
      vec_max_q <= vec_max_d;
    end
  end

  assign vec_max = vec_max_q;
`else
  assign vec_max = '0;
`endif

endmodule
